sink_list_updater: RTL and testbench
====================================

Name: sink_list_updater

Overview:
- Bus initiator for the 16-bit word memory: checks whether a sink ID is in the knownSinks list, and appends it if absent.
- Reads knownSinkCount, scans knownSinks word by word and reports found/index.
- On a miss with room, writes the ID to the next slot, then writes back the incremented count.
- Sits between the routing control FSM and the `mem` port; drives address/wr_en/data and samples the combinational read data.

Parameters:
- LIST_BASE, 16'h0008, byte address of knownSinks[0]; entries are 2 bytes apart.
- COUNT_ADDR, 16'h0688, byte address of knownSinkCount.
- MAX_ENTRIES, 16, list capacity in entries.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- nrst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- sink_id  in  16  ID to look up or append; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- found  out  1  ID was already present.
- full  out  1  ID absent and list at capacity; nothing written.
- result_index  out  16  entry index of the ID (found) or of the new slot (appended).
- mem_address  out  16  byte address to memory.
- mem_wr_en  out  1  memory write enable.
- mem_wdata  out  16  write data to memory (high byte goes to address, low byte to address+1).
- mem_rdata  in  16  memory read data; valid combinationally in the same cycle as mem_address.

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE.
  - busy, done, found, full, mem_wr_en = 0.
  - result_index, mem_address, mem_wdata = 0.
  - Latched id, count and idx = 0.
- Memory access rules:
  - Zero wait states: each read uses one cycle; mem_rdata is sampled at the rising edge ending that cycle.
  - mem_wr_en is asserted only in APPEND (on a non-full miss) and WR_CNT.
- States:
  - IDLE: mem_address=0, mem_wr_en=0. On start=1, latch sink_id, clear found/full/result_index, go to RD_CNT. start=0 stays in IDLE.
  - RD_CNT: mem_address=COUNT_ADDR. Latch count = min(mem_rdata, MAX_ENTRIES); idx=0. Go to SCAN if count≠0, else APPEND.
  - SCAN: mem_address = LIST_BASE + 2*idx, using 16-bit wrap-around arithmetic.
    - If mem_rdata==id: found=1, result_index=idx, go to DONE.
    - Else if idx==count-1: go to APPEND.
    - Else: idx++.
  - APPEND:
    - If count==MAX_ENTRIES: full=1, no write, go to DONE.
    - Else: mem_wr_en=1, mem_address = LIST_BASE + 2*count, mem_wdata=id, result_index=count, go to WR_CNT.
  - WR_CNT: mem_wr_en=1, mem_address=COUNT_ADDR, mem_wdata=count+1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. found/full/result_index hold until the next accepted start.
- Latency: the cycle start is accepted in IDLE is cycle 0. done is high in:
  - Hit at index k: cycle k+3.
  - Miss with append: cycle count+4.
  - Miss while full: cycle count+3.
- Boundaries:
  - start while busy: ignored, with no queueing.
  - start asserted in the DONE cycle: ignored; it is accepted only once back in IDLE.
  - Stored count > MAX_ENTRIES: clamped; only the first MAX_ENTRIES entries are scanned.
  - Duplicate entries in the list: the lowest index wins.
  - sink_id changing after acceptance: no effect.
  - Reset mid-operation: outputs are forced to reset values immediately.
    - If reset hits APPEND, the slot write may be lost, but count is not incremented, so the list stays consistent.
    - If reset hits WR_CNT, the slot data is written but may sit beyond the count; it is harmless.

Decomposition:
- Shared package `mem_map_pkg`:
  - Byte addresses for every region in the memory map: FLAGS, knownSinks, worstHops, neighborID, clusterID, batteryStat, qValue, sinkIDs, HCM, betterneighbors, and the four count words.
  - WORD_WIDTH=16 and MEM_WIDTH=8.
  - The state enum for this block.
- No sub-module: one FSM plus an address mux. The address computation (base + 2*idx) can become a shared function in the package for reuse by sibling scanners.

Test Plan:
- Preload knownSinks={2,5,10,171,205}, count=5; start, sink_id=10 -> done in cycle 5, found=1, result_index=2, no write cycles, count word still 5.
- Same preload; sink_id=99 -> one write of 0x0063 to 0x0012 and one of 0x0006 to 0x0688, in that order in consecutive cycles; done in cycle 9, found=0, full=0, result_index=5.
- count=0, sink_id=7 -> write 0x0007 to 0x0008, write 1 to 0x0688, done in cycle 4, result_index=0.
- count=16 with 16 distinct IDs, sink_id absent -> no mem_wr_en ever, full=1, done in cycle 19; with sink_id equal to the last entry -> found=1, result_index=15, done in cycle 18.
- start pulsed again during SCAN and during the DONE cycle -> ignored, single done pulse; drop nrst during WR_CNT -> mem_wr_en and busy go low asynchronously, FSM returns to IDLE; after release a fresh start completes normally.
- Count word =20 (over capacity), sink_id absent -> exactly 16 SCAN cycles, full=1, no write.

Source files
------------

// File: rtl/mem_map_pkg.sv
// ============================================================================
// Module  : mem_map_pkg
// Purpose : Shared memory map of the 16-bit word memory (byte addresses of
//           every region and count word), memory widths, the sink list
//           updater state encoding and a word-address helper shared by
//           list scanners.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_map_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_WIDTH  = 8;

  // Region base addresses (byte addresses, 2 bytes per word entry)
  localparam logic [15:0] FLAGS_ADDR            = 16'h0000;
  localparam logic [15:0] KNOWN_SINKS_ADDR      = 16'h0008;
  localparam logic [15:0] WORST_HOPS_ADDR       = 16'h0028;
  localparam logic [15:0] NEIGHBOR_ID_ADDR      = 16'h0048;
  localparam logic [15:0] CLUSTER_ID_ADDR       = 16'h0088;
  localparam logic [15:0] BATTERY_STAT_ADDR     = 16'h0108;
  localparam logic [15:0] Q_VALUE_ADDR          = 16'h0188;
  localparam logic [15:0] SINK_IDS_ADDR         = 16'h0288;
  localparam logic [15:0] HCM_ADDR              = 16'h0308;
  localparam logic [15:0] BETTER_NEIGHBORS_ADDR = 16'h0588;

  // Count words
  localparam logic [15:0] KNOWN_SINK_COUNT_ADDR      = 16'h0688;
  localparam logic [15:0] NEIGHBOR_COUNT_ADDR        = 16'h068A;
  localparam logic [15:0] SINK_ID_COUNT_ADDR         = 16'h068C;
  localparam logic [15:0] BETTER_NEIGHBOR_COUNT_ADDR = 16'h068E;

  typedef enum logic [2:0] {
    SLU_IDLE   = 3'd0,
    SLU_RD_CNT = 3'd1,
    SLU_SCAN   = 3'd2,
    SLU_APPEND = 3'd3,
    SLU_WR_CNT = 3'd4,
    SLU_DONE   = 3'd5
  } slu_state_e;

  // Byte address of word entry idx in a list starting at base; wraps at 16 bits.
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [15:0] idx);
    return base + {idx[14:0], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sink_list_updater.sv
// ============================================================================
// Module  : sink_list_updater
// Purpose : Bus initiator that looks up a sink ID in the knownSinks list and
//           appends it (then bumps knownSinkCount) when absent and there is
//           room.
// Ports   : clock, nrst        - clock, async active-low reset
//           start, sink_id     - request strobe (IDLE only) and ID to process
//           busy, done         - not-idle flag, one-cycle completion pulse
//           found, full        - hit flag, miss-at-capacity flag
//           result_index       - hit index or newly appended slot index
//           mem_address/wr_en/wdata, mem_rdata - zero-wait-state memory port
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sink_list_updater
  import mem_map_pkg::*;
#(
  parameter logic [15:0] LIST_BASE   = KNOWN_SINKS_ADDR,
  parameter logic [15:0] COUNT_ADDR  = KNOWN_SINK_COUNT_ADDR,
  parameter int          MAX_ENTRIES = 16
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] sink_id,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        full,
  output logic [15:0] result_index,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [15:0] C_MAX = 16'(MAX_ENTRIES);

  slu_state_e  r_state;
  slu_state_e  w_state_next;

  logic [15:0] r_id;
  logic [15:0] r_count;
  logic [15:0] r_idx;
  logic        r_found;
  logic        r_full;
  logic [15:0] r_result;

  logic [15:0] w_count_clamped;
  logic        w_hit;
  logic        w_last;
  logic        w_list_full;

  // A stored count above capacity is treated as capacity so the scan never
  // walks past the end of the list region.
  assign w_count_clamped = (mem_rdata > C_MAX) ? C_MAX : mem_rdata;
  assign w_hit           = (mem_rdata == r_id);
  // Only evaluated in SCAN, where r_count is at least 1.
  assign w_last          = (r_idx == (r_count - 16'd1));
  assign w_list_full     = (r_count == C_MAX);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state <= SLU_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and memory-port outputs. Outputs decode from the state
  // register only, so an asynchronous reset clears them immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    mem_address  = 16'h0000;
    mem_wr_en    = 1'b0;
    mem_wdata    = 16'h0000;

    case (r_state)
      SLU_IDLE: begin
        if (start) begin
          w_state_next = SLU_RD_CNT;
        end
      end
      SLU_RD_CNT: begin
        mem_address  = COUNT_ADDR;
        w_state_next = (w_count_clamped != 16'd0) ? SLU_SCAN : SLU_APPEND;
      end
      SLU_SCAN: begin
        mem_address = word_addr(LIST_BASE, r_idx);
        if (w_hit) begin
          w_state_next = SLU_DONE;
        end else if (w_last) begin
          w_state_next = SLU_APPEND;
        end
      end
      SLU_APPEND: begin
        if (w_list_full) begin
          w_state_next = SLU_DONE;
        end else begin
          mem_wr_en    = 1'b1;
          mem_address  = word_addr(LIST_BASE, r_count);
          mem_wdata    = r_id;
          w_state_next = SLU_WR_CNT;
        end
      end
      SLU_WR_CNT: begin
        mem_wr_en    = 1'b1;
        mem_address  = COUNT_ADDR;
        mem_wdata    = r_count + 16'd1;
        w_state_next = SLU_DONE;
      end
      SLU_DONE: begin
        w_state_next = SLU_IDLE;
      end
      default: begin
        w_state_next = SLU_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_id     <= 16'h0000;
      r_count  <= 16'h0000;
      r_idx    <= 16'h0000;
      r_found  <= 1'b0;
      r_full   <= 1'b0;
      r_result <= 16'h0000;
    end else begin
      case (r_state)
        SLU_IDLE: begin
          if (start) begin
            r_id     <= sink_id;
            r_found  <= 1'b0;
            r_full   <= 1'b0;
            r_result <= 16'h0000;
          end
        end
        SLU_RD_CNT: begin
          r_count <= w_count_clamped;
          r_idx   <= 16'h0000;
        end
        SLU_SCAN: begin
          if (w_hit) begin
            r_found  <= 1'b1;
            r_result <= r_idx;
          end else if (!w_last) begin
            r_idx <= r_idx + 16'd1;
          end
        end
        SLU_APPEND: begin
          if (w_list_full) begin
            r_full <= 1'b1;
          end else begin
            r_result <= r_count;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy         = (r_state != SLU_IDLE);
  assign done         = (r_state == SLU_DONE);
  assign found        = r_found;
  assign full         = r_full;
  assign result_index = r_result;

endmodule

`default_nettype wire

// File: tb/tb_sink_list_updater.sv
// ============================================================================
// Module  : tb_sink_list_updater
// Purpose : Directed self-checking bench for sink_list_updater with a
//           byte-addressed memory model and a write/scan activity log.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sink_list_updater;

  localparam logic [15:0] LB = 16'h0008;
  localparam logic [15:0] CA = 16'h0688;

  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        start = 1'b0;
  logic [15:0] sink_id = 16'h0000;
  logic        busy, done, found, full, mem_wr_en;
  logic [15:0] result_index, mem_address, mem_wdata, mem_rdata;

  logic [7:0]  mem [0:65535];
  logic [15:0] w_a1;

  logic [15:0] wl_addr [0:63];
  logic [15:0] wl_data [0:63];
  int          wl_cyc  [0:63];
  int          wr_total = 0;
  int          scan_total = 0;
  int          tick = 0;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the last run_op
  int t0, done_cyc, done_pulses, wr_base, scan_base;

  sink_list_updater dut (
    .clock        (clock),
    .nrst         (nrst),
    .start        (start),
    .sink_id      (sink_id),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .full         (full),
    .result_index (result_index),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  assign w_a1      = mem_address + 16'd1;
  assign mem_rdata = {mem[mem_address], mem[w_a1]};

  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem[mem_address] = mem_wdata[15:8];
      mem[w_a1]        = mem_wdata[7:0];
      wl_addr[wr_total & 63] = mem_address;
      wl_data[wr_total & 63] = mem_wdata;
      wl_cyc[wr_total & 63]  = tick;
      wr_total = wr_total + 1;
    end
    tick = tick + 1;
  end

  always @(negedge clock) begin
    if (nrst && busy && !mem_wr_en && mem_address >= LB && mem_address < LB + 16'd32)
      scan_total = scan_total + 1;
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic put_word(input logic [15:0] a, input logic [15:0] v);
    logic [15:0] a1;
    a1 = a + 16'd1;
    mem[a]  = v[15:8];
    mem[a1] = v[7:0];
  endtask

  function automatic logic [15:0] get_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic load_five();
    clear_mem();
    put_word(LB + 16'd0, 16'd2);
    put_word(LB + 16'd2, 16'd5);
    put_word(LB + 16'd4, 16'd10);
    put_word(LB + 16'd6, 16'd171);
    put_word(LB + 16'd8, 16'd205);
    put_word(CA, 16'd5);
  endtask

  task automatic load_sixteen(input logic [15:0] cnt);
    clear_mem();
    for (int i = 0; i < 16; i++) put_word(LB + 16'(2 * i), 16'(100 + i));
    put_word(CA, cnt);
  endtask

  // Issue one request; cycle 0 is the acceptance cycle. Optionally re-pulse
  // start in cycle poke_cyc and/or in the DONE cycle. sink_id is scrambled
  // after acceptance.
  task automatic run_op(input logic [15:0] id, input int poke_cyc, input bit poke_done);
    done_cyc    = -1;
    done_pulses = 0;
    wr_base     = wr_total;
    scan_base   = scan_total;
    @(negedge clock);
    t0      = tick;
    sink_id = id;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    sink_id = ~id;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(negedge clock);
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == poke_cyc || (poke_done && done && done_pulses == 1)) begin
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (found !== 1'b0) $display("FAIL reset_found got %b want 0", found); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_checks++; if (result_index !== 16'h0) $display("FAIL reset_index got %h want 0", result_index); else n_pass++;
    n_checks++; if (mem_address !== 16'h0) $display("FAIL reset_addr got %h want 0", mem_address); else n_pass++;
    n_checks++; if (mem_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", mem_wr_en); else n_pass++;
    n_checks++; if (mem_wdata !== 16'h0) $display("FAIL reset_wdata got %h want 0", mem_wdata); else n_pass++;
    nrst = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_hit();
    load_five();
    run_op(16'd10, 0, 1'b0);
    n_checks++; if (done_cyc !== 5) $display("FAIL hit_done_cycle got %0d want 5", done_cyc); else n_pass++;
    n_checks++; if (found !== 1'b1) $display("FAIL hit_found got %b want 1", found); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL hit_full got %b want 0", full); else n_pass++;
    n_checks++; if (result_index !== 16'd2) $display("FAIL hit_index got %0d want 2", result_index); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 0) $display("FAIL hit_writes got %0d want 0", wr_total - wr_base); else n_pass++;
    n_checks++; if (get_word(CA) !== 16'd5) $display("FAIL hit_count_word got %0d want 5", get_word(CA)); else n_pass++;
  endtask

  task automatic test_append();
    int b;
    load_five();
    run_op(16'd99, 0, 1'b0);
    b = wr_base & 63;
    n_checks++; if (done_cyc !== 9) $display("FAIL app_done_cycle got %0d want 9", done_cyc); else n_pass++;
    n_checks++; if (found !== 1'b0 || full !== 1'b0) $display("FAIL app_flags got found=%b full=%b want 0 0", found, full); else n_pass++;
    n_checks++; if (result_index !== 16'd5) $display("FAIL app_index got %0d want 5", result_index); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 2) $display("FAIL app_writes got %0d want 2", wr_total - wr_base); else n_pass++;
    n_checks++; if (wl_addr[b] !== 16'h0012 || wl_data[b] !== 16'h0063) $display("FAIL app_slot_write got %h<=%h want 0012<=0063", wl_addr[b], wl_data[b]); else n_pass++;
    n_checks++; if (wl_addr[(b+1)&63] !== CA || wl_data[(b+1)&63] !== 16'h0006) $display("FAIL app_count_write got %h<=%h want 0688<=0006", wl_addr[(b+1)&63], wl_data[(b+1)&63]); else n_pass++;
    n_checks++; if (wl_cyc[b] - t0 !== 7 || wl_cyc[(b+1)&63] - t0 !== 8) $display("FAIL app_write_cycles got %0d,%0d want 7,8", wl_cyc[b] - t0, wl_cyc[(b+1)&63] - t0); else n_pass++;
    n_checks++; if (get_word(16'h0012) !== 16'd99 || get_word(CA) !== 16'd6) $display("FAIL app_memory got %0d,%0d want 99,6", get_word(16'h0012), get_word(CA)); else n_pass++;
  endtask

  task automatic test_empty();
    int b;
    clear_mem();
    put_word(CA, 16'd0);
    run_op(16'd7, 0, 1'b0);
    b = wr_base & 63;
    n_checks++; if (done_cyc !== 4) $display("FAIL empty_done_cycle got %0d want 4", done_cyc); else n_pass++;
    n_checks++; if (result_index !== 16'd0 || found !== 1'b0) $display("FAIL empty_result got idx=%0d found=%b want 0 0", result_index, found); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 2) $display("FAIL empty_writes got %0d want 2", wr_total - wr_base); else n_pass++;
    n_checks++; if (wl_addr[b] !== LB || wl_data[b] !== 16'h0007) $display("FAIL empty_slot_write got %h<=%h want 0008<=0007", wl_addr[b], wl_data[b]); else n_pass++;
    n_checks++; if (wl_addr[(b+1)&63] !== CA || wl_data[(b+1)&63] !== 16'h0001) $display("FAIL empty_count_write got %h<=%h want 0688<=0001", wl_addr[(b+1)&63], wl_data[(b+1)&63]); else n_pass++;
  endtask

  task automatic test_full();
    load_sixteen(16'd16);
    run_op(16'd500, 0, 1'b0);
    n_checks++; if (done_cyc !== 19) $display("FAIL full_done_cycle got %0d want 19", done_cyc); else n_pass++;
    n_checks++; if (full !== 1'b1 || found !== 1'b0) $display("FAIL full_flags got full=%b found=%b want 1 0", full, found); else n_pass++;
    n_checks++; if (result_index !== 16'd0) $display("FAIL full_index got %0d want 0", result_index); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 0) $display("FAIL full_writes got %0d want 0", wr_total - wr_base); else n_pass++;
    n_checks++; if (scan_total - scan_base !== 16) $display("FAIL full_scan_cycles got %0d want 16", scan_total - scan_base); else n_pass++;
    run_op(16'd115, 0, 1'b0);
    n_checks++; if (done_cyc !== 18) $display("FAIL last_done_cycle got %0d want 18", done_cyc); else n_pass++;
    n_checks++; if (found !== 1'b1 || full !== 1'b0) $display("FAIL last_flags got found=%b full=%b want 1 0", found, full); else n_pass++;
    n_checks++; if (result_index !== 16'd15) $display("FAIL last_index got %0d want 15", result_index); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 0) $display("FAIL last_writes got %0d want 0", wr_total - wr_base); else n_pass++;
  endtask

  task automatic test_clamp();
    load_sixteen(16'd20);
    run_op(16'd600, 0, 1'b0);
    n_checks++; if (scan_total - scan_base !== 16) $display("FAIL clamp_scan_cycles got %0d want 16", scan_total - scan_base); else n_pass++;
    n_checks++; if (full !== 1'b1) $display("FAIL clamp_full got %b want 1", full); else n_pass++;
    n_checks++; if (done_cyc !== 19) $display("FAIL clamp_done_cycle got %0d want 19", done_cyc); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 0 || get_word(CA) !== 16'd20) $display("FAIL clamp_no_write got writes=%0d count=%0d want 0 20", wr_total - wr_base, get_word(CA)); else n_pass++;
  endtask

  task automatic test_duplicate();
    clear_mem();
    put_word(LB + 16'd0, 16'd2);
    put_word(LB + 16'd2, 16'd10);
    put_word(LB + 16'd4, 16'd7);
    put_word(LB + 16'd6, 16'd10);
    put_word(CA, 16'd4);
    run_op(16'd10, 0, 1'b0);
    n_checks++; if (result_index !== 16'd1 || found !== 1'b1) $display("FAIL dup_index got idx=%0d found=%b want 1 1", result_index, found); else n_pass++;
    n_checks++; if (done_cyc !== 4) $display("FAIL dup_done_cycle got %0d want 4", done_cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    load_five();
    run_op(16'd205, 3, 1'b1);
    n_checks++; if (done_cyc !== 7) $display("FAIL b2b_done_cycle got %0d want 7", done_cyc); else n_pass++;
    n_checks++; if (done_pulses !== 1) $display("FAIL b2b_done_pulses got %0d want 1", done_pulses); else n_pass++;
    n_checks++; if (found !== 1'b1 || result_index !== 16'd4) $display("FAIL b2b_result got found=%b idx=%0d want 1 4", found, result_index); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy); else n_pass++;
    n_checks++; if (wr_total - wr_base !== 0) $display("FAIL b2b_writes got %0d want 0", wr_total - wr_base); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_mem();
    put_word(CA, 16'd0);
    @(negedge clock);
    sink_id = 16'd7;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (mem_wr_en !== 1'b1 || mem_address !== CA) $display("FAIL mid_in_wr_cnt got wr_en=%b addr=%h want 1 0688", mem_wr_en, mem_address); else n_pass++;
    #2;
    nrst = 1'b0;
    #1;
    n_checks++; if (mem_wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL mid_async_clear got wr_en=%b busy=%b want 0 0", mem_wr_en, busy); else n_pass++;
    n_checks++; if (mem_address !== 16'h0 || mem_wdata !== 16'h0 || done !== 1'b0) $display("FAIL mid_async_outputs got addr=%h wdata=%h done=%b want 0 0 0", mem_address, mem_wdata, done); else n_pass++;
    @(posedge clock);
    @(negedge clock);
    nrst = 1'b1;
    n_checks++; if (get_word(CA) !== 16'd0) $display("FAIL mid_count_kept got %0d want 0", get_word(CA)); else n_pass++;
    run_op(16'd9, 0, 1'b0);
    n_checks++; if (done_cyc !== 4 || result_index !== 16'd0) $display("FAIL mid_rerun got cycle=%0d idx=%0d want 4 0", done_cyc, result_index); else n_pass++;
    n_checks++; if (get_word(LB) !== 16'd9 || get_word(CA) !== 16'd1) $display("FAIL mid_rerun_mem got %0d,%0d want 9,1", get_word(LB), get_word(CA)); else n_pass++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_hit();
    test_append();
    test_empty();
    test_full();
    test_clamp();
    test_duplicate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
